fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage sitting directly upstream of the decode stage. It owns the program counter and fetches 16-bit instructions from a variable-latency instruction memory through a req/rdy handshake. It presents one instruction at a time to decode with a valid/ready handshake. It also handles control-flow redirects, the HALT opcode and misaligned-target errors.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset; must be even.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction memory request; forced 0 while rst=1
- imem_addr  out  16  fetch address, equals current PC
- imem_rdy  in  1  memory completes request this cycle; imem_data valid
- imem_data  in  16  fetched instruction word
- instr  out  16  instruction presented to decode
- instr_pc  out  16  address of instr
- pc_plus2  out  16  instr_pc + 2 (mod 2^16)
- instr_valid  out  1  instr/instr_pc/pc_plus2 valid
- instr_ready  in  1  decode accepts instr when instr_valid & instr_ready
- redirect  in  1  one-cycle branch/jump redirect request
- redirect_pc  in  16  redirect target
- halted  out  1  sticky; HALT delivered, fetching stopped
- err  out  1  sticky; misaligned target detected

## Operation
- State machine with states FETCH, HOLD, DRAIN, HALTED, ERR. Reset state is FETCH.
- imem_req = ~rst & (state==FETCH | state==DRAIN). imem_addr = pc.
- Once raised, imem_req and imem_addr stay stable until imem_rdy=1. The only exception is assertion of rst.
- FETCH
  - imem_rdy=1, no redirect: capture instr<=imem_data, instr_pc<=pc, pc_plus2<=pc+2, pc<=pc+2, instr_valid<=1, go to HOLD.
  - imem_rdy=1 with redirect: discard imem_data. If redirect_pc[0]=0, pc<=redirect_pc and stay in FETCH; otherwise go to ERR.
  - imem_rdy=0 with redirect: latch the target in pend_pc and go to DRAIN.
- DRAIN
  - Keep the outstanding request.
  - A new redirect overwrites pend_pc, and takes priority when it coincides with imem_rdy.
  - On imem_rdy: discard data. If pend_pc[0]=0, pc<=pend_pc and go to FETCH; otherwise go to ERR.
- HOLD
  - instr_valid=1 and outputs are held stable until accepted.
  - redirect has priority over acceptance: instr_valid<=0 (the instruction is squashed even if instr_ready=1). If the target is even, pc<=redirect_pc and go to FETCH; otherwise go to ERR.
  - Accepted with instr[15:11]==5'b00000 (HALT): instr_valid<=0, halted<=1, go to HALTED.
  - Accepted otherwise: instr_valid<=0, go to FETCH.
- HALTED / ERR: terminal. No requests are issued and redirects are ignored. halted=1 or err=1 respectively; only rst exits.
- PC arithmetic is 16-bit and wraps from 16'hFFFE to 16'h0000 silently; no error is raised.

## Timing
- Reset values: pc=RESET_PC, instr=16'h0800 (NOP), instr_pc=RESET_PC, pc_plus2=RESET_PC+2, instr_valid=0, halted=0, err=0, imem_req=0 during reset.
- imem_req rises in the first cycle after rst deasserts.
- Latency:
  - instr_valid rises on the edge where imem_rdy=1 is sampled.
  - With zero-wait memory (imem_rdy=1 combinationally) and instr_ready held high, throughput is 1 instruction per 2 cycles.
  - A redirect in HOLD lets the next request issue in the following cycle.
- The squash rule is fixed: instr_valid is never high on the edge after a redirect is sampled.
- Reset mid-operation clears all state immediately and abandons any outstanding request. The memory must tolerate req dropping at reset.
- Simultaneous redirect and HALT acceptance in HOLD: the redirect wins and halted stays 0.

## Test plan
- Reset with RESET_PC=0 and zero-wait memory returning 16'h4100, 16'h4200, with instr_ready=1. Required: instr_pc sequence 0000, 0002; pc_plus2 0002, 0004; instr_valid pattern 1,0,1.
- 3-cycle memory latency with instr_ready=0 for 4 cycles in HOLD. Required: imem_addr stable during wait; instr held stable and instr_valid=1 throughout; no new imem_req until acceptance.
- redirect to 16'h0040 at cycle 1 of a 3-cycle request. Required: stale data discarded and instr_valid never rises for it; the next imem_addr is 0040.
- redirect to 16'h0041 in HOLD. Required: instr_valid=0 and err=1 next cycle; imem_req stays 0 while redirects are ignored. After rst, err=0.
- HALT word 16'h0000 fetched and accepted. Required: halted=1 next cycle, imem_req=0 forever, and a later redirect has no effect.
- PC at 16'hFFFE. Required: next fetch address is 16'h0000 and err stays 0.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage feeding decode. Owns the program counter, fetches
// 16-bit words from a variable-latency instruction memory (req/rdy), and hands
// one instruction at a time to decode (valid/ready). Handles control-flow
// redirects, the HALT opcode (instr[15:11] == 5'b00000) and odd redirect
// targets, which park the stage in a sticky error state.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   imem_req     memory request (held with imem_addr until imem_rdy)
//   imem_addr    fetch address (current PC)
//   imem_rdy     memory completes the request this cycle
//   imem_data    fetched word, valid with imem_rdy
//   instr        instruction presented to decode
//   instr_pc     address of instr
//   pc_plus2     instr_pc + 2 (wraps at 16 bits)
//   instr_valid  instr / instr_pc / pc_plus2 are valid
//   instr_ready  decode accepts when instr_valid & instr_ready
//   redirect     one-cycle redirect request
//   redirect_pc  redirect target
//   halted       sticky, HALT was delivered and fetching stopped
//   err          sticky, a misaligned target was seen
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted,
  output logic        err
);

  localparam logic [15:0] NOP_WORD = 16'h0800;

  typedef enum logic [2:0] {
    FETCH,   // request outstanding for pc
    HOLD,    // instruction presented, waiting for decode
    DRAIN,   // request outstanding whose data will be thrown away
    HALTED,  // terminal after HALT
    ERR      // terminal after misaligned target
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] pend_pc, pend_pc_nxt;
  logic [15:0] instr_nxt, instr_pc_nxt, pc_plus2_nxt;
  logic        instr_valid_nxt, halted_nxt, err_nxt;

  // A redirect resolves through one shared path whichever state it lands in.
  logic        jump;
  logic [15:0] jump_pc;

  assign imem_req  = ~rst & ((state == FETCH) | (state == DRAIN));
  assign imem_addr = pc;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; otherwise the combinational block would infer latches.
    state_nxt       = state;
    pc_nxt          = pc;
    pend_pc_nxt     = pend_pc;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    pc_plus2_nxt    = pc_plus2;
    instr_valid_nxt = instr_valid;
    halted_nxt      = halted;
    err_nxt         = err;
    jump            = 1'b0;
    jump_pc         = redirect_pc;

    unique case (state)
      FETCH: begin
        if (imem_rdy) begin
          if (redirect) begin
            // Returned word belongs to the abandoned path.
            jump = 1'b1;
          end else begin
            instr_nxt       = imem_data;
            instr_pc_nxt    = pc;
            pc_plus2_nxt    = pc + 16'd2;
            pc_nxt          = pc + 16'd2;
            instr_valid_nxt = 1'b1;
            state_nxt       = HOLD;
          end
        end else if (redirect) begin
          // The request cannot be withdrawn, so remember where to go once
          // memory finishes it.
          pend_pc_nxt = redirect_pc;
          state_nxt   = DRAIN;
        end
      end

      DRAIN: begin
        if (redirect) begin
          pend_pc_nxt = redirect_pc;
        end
        if (imem_rdy) begin
          jump    = 1'b1;
          jump_pc = redirect ? redirect_pc : pend_pc;
        end
      end

      HOLD: begin
        if (redirect) begin
          // Redirect beats acceptance, including acceptance of a HALT.
          instr_valid_nxt = 1'b0;
          jump            = 1'b1;
        end else if (instr_ready) begin
          instr_valid_nxt = 1'b0;
          if (instr[15:11] == 5'b00000) begin
            halted_nxt = 1'b1;
            state_nxt  = HALTED;
          end else begin
            state_nxt = FETCH;
          end
        end
      end

      HALTED, ERR: begin
        state_nxt = state;
      end

      default: begin
        state_nxt = ERR;
        err_nxt   = 1'b1;
      end
    endcase

    if (jump) begin
      if (jump_pc[0]) begin
        state_nxt = ERR;
        err_nxt   = 1'b1;
      end else begin
        pc_nxt    = jump_pc;
        state_nxt = FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      pend_pc     <= RESET_PC;
      instr       <= NOP_WORD;
      instr_pc    <= RESET_PC;
      pc_plus2    <= RESET_PC + 16'd2;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state       <= state_nxt;
      pc          <= pc_nxt;
      pend_pc     <= pend_pc_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      pc_plus2    <= pc_plus2_nxt;
      instr_valid <= instr_valid_nxt;
      halted      <= halted_nxt;
      err         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Drives fetch_stage with a variable-latency memory, redirects, decode back
// pressure and resets. A behavioural model predicts the instruction stream:
// every time the model says a word is handed to decode it pushes the expected
// {word, pc, pc+2} into a queue, and an independent monitor pops and compares
// whenever instr_valid rises. Handshake and status outputs are compared every
// cycle against the model.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;
  logic        err;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc_plus2    (pc_plus2),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------------------------------------------------------- memory --
  logic [15:0] mem_ovr [logic [15:0]];
  int lat_min = 0;
  int lat_max = 0;
  int lat_left = 0;
  bit hs = 1'b0;       // handshake offered for the coming edge
  bit req_drv = 1'b0;  // model expected a request for the coming edge

  // Default contents always have bit 11 set, so only explicit overrides can
  // hold a HALT word.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[7:0] ^ 8'hA5, a[15:8]} | 16'h0800;
  endfunction

  function automatic int pick_lat();
    return int'($urandom_range(lat_max, lat_min));
  endfunction

  // ----------------------------------------------------------------- model --
  typedef struct {
    logic [15:0] word;
    logic [15:0] pc;
    logic [15:0] next;
  } exp_t;

  exp_t        exp_q [$];
  logic [15:0] m_pc;      // next address the program wants
  logic [15:0] m_tgt;     // where to go once the abandoned fetch returns
  logic [15:0] m_word;    // word currently offered to decode
  bit          m_show;    // a word is offered to decode
  bit          m_discard; // memory still owes a word nobody wants
  bit          m_halt;
  bit          m_err;

  function automatic bit m_busy();
    return !m_show && !m_halt && !m_err;
  endfunction

  task automatic model_reset();
    m_pc      = RESET_PC;
    m_tgt     = RESET_PC;
    m_word    = 16'h0800;
    m_show    = 1'b0;
    m_discard = 1'b0;
    m_halt    = 1'b0;
    m_err     = 1'b0;
  endtask

  task automatic go_to(input logic [15:0] t);
    if (t[0]) m_err = 1'b1;
    else      m_pc  = t;
  endtask

  task automatic model_step(input logic rd, input logic [15:0] rpc, input logic acc,
                            input logic rdy);
    exp_t e;
    if (m_halt || m_err) return;
    if (m_show) begin
      if (rd) begin
        m_show = 1'b0;
        go_to(rpc);
      end else if (acc) begin
        m_show = 1'b0;
        if (m_word[15:11] == 5'd0) m_halt = 1'b1;
      end
    end else if (m_discard) begin
      if (rd) m_tgt = rpc;
      if (rdy) begin
        m_discard = 1'b0;
        go_to(m_tgt);
      end
    end else if (rd) begin
      if (rdy) go_to(rpc);
      else begin
        m_discard = 1'b1;
        m_tgt     = rpc;
      end
    end else if (rdy) begin
      m_word = mem_word(m_pc);
      e.word = m_word;
      e.pc   = m_pc;
      e.next = m_pc + 16'd2;
      exp_q.push_back(e);
      m_pc   = m_pc + 16'd2;
      m_show = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------- driver --
  // One clock cycle: settle memory bookkeeping for the edge just passed,
  // compare outputs with the model, then apply new inputs and advance the
  // model to the edge ahead.
  task automatic cycle(input logic r, input logic rd, input logic [15:0] rpc,
                       input logic acc);
    @(negedge clk);
    if (hs) lat_left = pick_lat();
    else if (req_drv && lat_left > 0) lat_left--;

    if (rst) begin
      check("rst_imem_req", 16'(imem_req), 16'h0);
      check("rst_instr", instr, 16'h0800);
      check("rst_instr_pc", instr_pc, RESET_PC);
      check("rst_pc_plus2", pc_plus2, RESET_PC + 16'd2);
      check("rst_valid", 16'(instr_valid), 16'h0);
      check("rst_halted", 16'(halted), 16'h0);
      check("rst_err", 16'(err), 16'h0);
    end else begin
      check("imem_req", 16'(imem_req), 16'(m_busy()));
      if (m_busy()) check("imem_addr", imem_addr, m_pc);
      check("instr_valid", 16'(instr_valid), 16'(m_show));
      check("halted", 16'(halted), 16'(m_halt));
      check("err", 16'(err), 16'(m_err));
    end

    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    instr_ready = acc;
    if (r) begin
      model_reset();
      lat_left  = pick_lat();
      hs        = 1'b0;
      req_drv   = 1'b0;
      imem_rdy  = 1'b0;
      imem_data = 16'($urandom);
    end else begin
      req_drv   = m_busy();
      imem_rdy  = req_drv && (lat_left == 0);
      hs        = imem_rdy;
      imem_data = imem_rdy ? mem_word(imem_addr) : 16'($urandom);
      model_step(rd, rpc, acc, imem_rdy);
    end
  endtask

  task automatic idle(input int n, input logic acc);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, acc);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_min = lo;
    lat_max = hi;
  endtask

  // --------------------------------------------------------------- monitor --
  initial begin
    bit          pv;
    logic [15:0] p_instr, p_pc, p_next;
    exp_t        e;
    pv = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (instr_valid && !pv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 16'(instr_valid), 16'h0);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr", instr, e.word);
          check("sb_instr_pc", instr_pc, e.pc);
          check("sb_pc_plus2", pc_plus2, e.next);
        end
      end else if (instr_valid && pv) begin
        check("hold_instr", instr, p_instr);
        check("hold_instr_pc", instr_pc, p_pc);
        check("hold_pc_plus2", pc_plus2, p_next);
      end
      pv      = instr_valid;
      p_instr = instr;
      p_pc    = instr_pc;
      p_next  = pc_plus2;
    end
  end

  // ------------------------------------------------------------- stimulus --
  initial begin
    logic [31:0] t;
    logic [15:0] rpc;
    logic        r, rd, acc;
    int          dead_cnt;

    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    instr_ready = 1'b0;
    imem_rdy    = 1'b0;
    imem_data   = 16'h0;
    model_reset();

    mem_ovr[16'h0000] = 16'h4100;
    mem_ovr[16'h0002] = 16'h4200;
    mem_ovr[16'h0100] = 16'h0000;  // HALT

    // Zero-wait memory, decode always ready.
    set_lat(0, 0);
    do_reset(3);
    idle(6, 1'b1);

    // Three-cycle memory, decode stalls four cycles in HOLD.
    set_lat(2, 2);
    do_reset(2);
    idle(7, 1'b0);
    idle(6, 1'b1);

    // Redirect during an outstanding three-cycle request.
    do_reset(2);
    idle(1, 1'b1);
    cycle(1'b0, 1'b1, 16'h0040, 1'b1);
    idle(8, 1'b1);

    // Odd redirect while holding: error, later redirects ignored, reset clears.
    set_lat(0, 0);
    do_reset(2);
    idle(1, 1'b0);
    cycle(1'b0, 1'b1, 16'h0041, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0010, 1'b1);
    do_reset(2);
    idle(3, 1'b1);

    // HALT fetched and accepted; later redirects have no effect.
    do_reset(2);
    cycle(1'b0, 1'b1, 16'h0100, 1'b1);
    idle(3, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0040, 1'b1);
    idle(3, 1'b1);

    // Redirect coinciding with acceptance of a HALT word: redirect wins.
    do_reset(2);
    cycle(1'b0, 1'b1, 16'h0100, 1'b0);
    idle(1, 1'b0);
    cycle(1'b0, 1'b1, 16'h0020, 1'b1);
    idle(4, 1'b1);

    // PC wrap from FFFE to 0000.
    do_reset(2);
    cycle(1'b0, 1'b1, 16'hFFFE, 1'b1);
    idle(6, 1'b1);

    // Randomised traffic.
    set_lat(0, 3);
    do_reset(2);
    dead_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      t   = $urandom;
      rpc = t[15:0] & 16'hFFFE;
      case (t[19:16])
        4'd0:    rpc = rpc | 16'h0001;
        4'd1:    rpc = 16'hFFFE;
        4'd2:    rpc = 16'h0100;
        default: ;
      endcase
      rd  = (t[23:21] == 3'd0);
      acc = (t[25:24] != 2'd0);
      dead_cnt = (m_halt || m_err) ? dead_cnt + 1 : 0;
      r   = (t[31:26] == 6'd0) || (dead_cnt > 4);
      if (r) dead_cnt = 0;
      cycle(r, rd, rpc, acc);
    end

    idle(4, 1'b1);
    @(negedge clk);
    check("queue_empty", 16'(exp_q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
